// File: rtl/ex_muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide for the EX stage (shift-add multiply, restoring divide).
// Latency: XLEN+1 cycles from start to result_valid; divide-by-zero/overflow finish in 1 cycle.
// Backpressure: holds the pipeline through stall_req until DONE; kill aborts the op in any state.
//
// Ports:
//   clk, rst_n      pipeline clock (rising edge), asynchronous active-low reset
//   accel_instr_ex  EX holds an M-extension op; funct3_ex selects which one
//   op_a, op_b      forwarded rs1/rs2 values, sampled only when the op starts
//   kill            flush of EX: abandon the op, return to IDLE
//   stall_req       hold IF/ID/EX while the op is in progress
//   busy            unit is not idle
//   result_valid    result is final this cycle (DONE)
//   result          rd write data; holds its last value between ops
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            accel_instr_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            stall_req,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic            r_neg_q;   // product / quotient sign
  logic            r_neg_r;   // remainder sign (dividend sign)
  logic [XLEN-1:0] r_b;       // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier shifting out / dividend shifting into quotient
  logic [XLEN-1:0] r_result;

  // ---- operand decode at start ----
  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic            w_div_zero, w_ovf, w_special, w_start, w_last;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;

  assign w_is_div   = funct3_ex[2];
  assign w_a_signed = w_is_div ? ~funct3_ex[0] : (funct3_ex[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~funct3_ex[0] : ~funct3_ex[1];
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -op_a : op_a;
  assign w_b_mag    = w_b_neg ? -op_b : op_b;

  assign w_div_zero = w_is_div & (op_b == '0);
  assign w_ovf      = w_is_div & ~funct3_ex[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign w_special  = w_div_zero | w_ovf;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign w_special_res = w_div_zero ? (funct3_ex[1] ? op_a : '1)
                                    : (funct3_ex[1] ? '0 : op_a);

  assign w_start = accel_instr_ex & ~kill & (r_state == S_IDLE);
  assign w_last  = (r_cnt == CW'(XLEN-1));

  // ---- one iteration ----
  logic [XLEN:0]   w_mul_sum, w_trial, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

  // Multiply: add multiplicand into high half when the next multiplier bit is set, shift right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: shift next dividend bit into the remainder; keep the subtraction if it did not borrow.
  assign w_trial   = {r_hi, r_lo[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_b};
  assign w_qbit    = ~w_diff[XLEN];

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_funct3[2]) begin
      w_hi_nxt = w_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // ---- sign fix-up on the final iteration ----
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  assign w_prod   = {w_hi_nxt, w_lo_nxt};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -w_lo_nxt : w_lo_nxt;
  assign w_rem    = r_neg_r ? -w_hi_nxt : w_hi_nxt;

  always_comb begin
    w_final = '0;
    if (r_funct3[2])               w_final = r_funct3[1] ? w_rem : w_quo;
    else if (r_funct3[1:0] == 2'b00) w_final = w_prod_s[XLEN-1:0];
    else                           w_final = w_prod_s[2*XLEN-1:XLEN];
  end

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = w_special ? S_DONE : S_BUSY;
      S_BUSY: if (w_last)  w_state_nxt = S_DONE;
      S_DONE:              w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (kill) begin
      r_cnt <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_funct3 <= funct3_ex;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_b      <= w_b_mag;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + CW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      if (w_last) r_result <= w_final;
    end
  end

  assign stall_req    = accel_instr_ex & ~kill & (r_state != S_DONE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;

  // The instruction must stay in EX for the whole iteration unless it is flushed.
  a_instr_held: assert property (@(posedge clk) disable iff (!rst_n)
                                 (r_state == S_BUSY) |-> (accel_instr_ex | kill));

endmodule
